// File: rtl/pll_mode_sequencer_if.sv
// Mode-change request handshake between the video controller and the PLL sequencer.
interface pll_mode_sequencer_if;
    logic mode_sel;
    logic mode_valid;
    logic mode_ready;

    modport master (output mode_sel, output mode_valid, input mode_ready);
    modport slave  (input mode_sel, input mode_valid, output mode_ready);
endinterface

// File: rtl/pll_mode_sequencer.sv
// Sequences the HDMI rPLL: applies a divider preset under reset, qualifies LOCK,
// and releases downstream video logic only after lock has been stable for a while.
module pll_mode_sequencer #(
    parameter logic [5:0] MODE0_IDSEL    = 6'd60,
    parameter logic [5:0] MODE0_FBDSEL   = 6'd9,
    parameter logic [5:0] MODE0_ODSEL    = 6'd62,
    parameter logic [5:0] MODE1_IDSEL    = 6'd62,
    parameter logic [5:0] MODE1_FBDSEL   = 6'd43,
    parameter logic [5:0] MODE1_ODSEL    = 6'd60,
    parameter int         RESET_CYCLES   = 16,
    parameter int         STABLE_CYCLES  = 1024,
    parameter int         TIMEOUT_CYCLES = 1048576
) (
    input  logic                        clk,
    input  logic                        reset,
    pll_mode_sequencer_if.slave         req,
    input  logic                        pll_lock,
    output logic                        pll_reset,
    output logic [5:0]                  pll_idsel,
    output logic [5:0]                  pll_fbdsel,
    output logic [5:0]                  pll_odsel,
    output logic                        cur_mode,
    output logic                        ready,
    output logic                        video_reset,
    output logic                        lock_lost,
    output logic                        timeout_err
);

    localparam int RESET_W   = (RESET_CYCLES   > 1) ? $clog2(RESET_CYCLES)   : 1;
    localparam int STABLE_W  = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // One shared interval counter, wide enough for the longest of the three waits.
    localparam int CW_A = (RESET_W > STABLE_W) ? RESET_W : STABLE_W;
    localparam int CW   = (CW_A > TIMEOUT_W) ? CW_A : TIMEOUT_W;

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {APPLY, WAIT_LOCK, STABLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lock_m;
    logic          lock_s;
    logic          mode_ready_q;

    assign req.mode_ready = mode_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // mode_ready is registered as next cycle's lock_s, so in RUN it always equals lock_s.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= APPLY;
            cnt          <= '0;
            pll_reset    <= 1'b1;
            video_reset  <= 1'b1;
            ready        <= 1'b0;
            mode_ready_q <= 1'b0;
            cur_mode     <= 1'b0;
            pll_idsel    <= MODE0_IDSEL;
            pll_fbdsel   <= MODE0_FBDSEL;
            pll_odsel    <= MODE0_ODSEL;
            lock_lost    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                APPLY: begin
                    if (cnt == RESET_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= APPLY;
                        cnt         <= '0;
                        pll_reset   <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state        <= RUN;
                        cnt          <= '0;
                        ready        <= 1'b1;
                        video_reset  <= 1'b0;
                        timeout_err  <= 1'b0;
                        mode_ready_q <= lock_m;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state        <= APPLY;
                        cnt          <= '0;
                        lock_lost    <= 1'b1;
                        ready        <= 1'b0;
                        video_reset  <= 1'b1;
                        pll_reset    <= 1'b1;
                        mode_ready_q <= 1'b0;
                    end else if (req.mode_valid && mode_ready_q) begin
                        // Selects only ever change here; lock loss and timeout reapply the same preset.
                        state        <= APPLY;
                        cnt          <= '0;
                        cur_mode     <= req.mode_sel;
                        pll_idsel    <= req.mode_sel ? MODE1_IDSEL  : MODE0_IDSEL;
                        pll_fbdsel   <= req.mode_sel ? MODE1_FBDSEL : MODE0_FBDSEL;
                        pll_odsel    <= req.mode_sel ? MODE1_ODSEL  : MODE0_ODSEL;
                        lock_lost    <= 1'b0;
                        ready        <= 1'b0;
                        video_reset  <= 1'b1;
                        pll_reset    <= 1'b1;
                        mode_ready_q <= 1'b0;
                    end else begin
                        mode_ready_q <= lock_m;
                    end
                end
                default: begin
                    state <= APPLY;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Directed bench for pll_mode_sequencer with short intervals (reset 4, stable 8, timeout 32).
module tb_pll_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       cur_mode;
    logic       ready;
    logic       video_reset;
    logic       lock_lost;
    logic       timeout_err;
    int         total = 0;
    int         bad = 0;

    localparam logic [17:0] SEL0 = {6'd60, 6'd9, 6'd62};
    localparam logic [17:0] SEL1 = {6'd62, 6'd43, 6'd60};

    pll_mode_sequencer_if req_if ();

    pll_mode_sequencer #(
        .RESET_CYCLES   (4),
        .STABLE_CYCLES  (8),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req_if.slave),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_idsel   (pll_idsel),
        .pll_fbdsel  (pll_fbdsel),
        .pll_odsel   (pll_odsel),
        .cur_mode    (cur_mode),
        .ready       (ready),
        .video_reset (video_reset),
        .lock_lost   (lock_lost),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pll_lock = 1'b0; req_if.mode_valid = 1'b0; req_if.mode_sel = 1'b0;
        tick(3);
        total++; if (pll_reset !== 1'b1) begin bad++; $display("[TB] FAIL rst_pll_reset: got=%0b exp=1", pll_reset); end
        total++; if (video_reset !== 1'b1) begin bad++; $display("[TB] FAIL rst_video_reset: got=%0b exp=1", video_reset); end
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got=%0b exp=0", ready); end
        total++; if (req_if.mode_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_mode_ready: got=%0b exp=0", req_if.mode_ready); end
        total++; if (cur_mode !== 1'b0) begin bad++; $display("[TB] FAIL rst_cur_mode: got=%0b exp=0", cur_mode); end
        total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== SEL0) begin bad++; $display("[TB] FAIL rst_selects: got=%h exp=%h", {pll_idsel, pll_fbdsel, pll_odsel}, SEL0); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("[TB] FAIL rst_lock_lost: got=%0b exp=0", lock_lost); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_timeout_err: got=%0b exp=0", timeout_err); end
    endtask

    task automatic test_lock_sequence();
        reset = 1'b0;
        tick(3);
        total++; if (pll_reset !== 1'b1) begin bad++; $display("[TB] FAIL seq_pll_reset_held: got=%0b exp=1", pll_reset); end
        tick(1);
        total++; if (pll_reset !== 1'b0) begin bad++; $display("[TB] FAIL seq_pll_reset_release: got=%0b exp=0", pll_reset); end
        tick(6);
        pll_lock = 1'b1;
        tick(10);
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL seq_ready_early: got=%0b exp=0", ready); end
        total++; if (video_reset !== 1'b1) begin bad++; $display("[TB] FAIL seq_video_reset_early: got=%0b exp=1", video_reset); end
        tick(1);
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL seq_ready: got=%0b exp=1", ready); end
        total++; if (video_reset !== 1'b0) begin bad++; $display("[TB] FAIL seq_video_reset: got=%0b exp=0", video_reset); end
        total++; if (req_if.mode_ready !== 1'b1) begin bad++; $display("[TB] FAIL seq_mode_ready: got=%0b exp=1", req_if.mode_ready); end
        total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== SEL0) begin bad++; $display("[TB] FAIL seq_selects: got=%h exp=%h", {pll_idsel, pll_fbdsel, pll_odsel}, SEL0); end
    endtask

    task automatic test_mode_change();
        req_if.mode_sel = 1'b1; req_if.mode_valid = 1'b1;
        total++; if (req_if.mode_ready !== 1'b1) begin bad++; $display("[TB] FAIL mc_ready_before: got=%0b exp=1", req_if.mode_ready); end
        tick(1);
        req_if.mode_valid = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL mc_ready_drop: got=%0b exp=0", ready); end
        total++; if (video_reset !== 1'b1) begin bad++; $display("[TB] FAIL mc_video_reset: got=%0b exp=1", video_reset); end
        total++; if (pll_reset !== 1'b1) begin bad++; $display("[TB] FAIL mc_pll_reset: got=%0b exp=1", pll_reset); end
        total++; if (cur_mode !== 1'b1) begin bad++; $display("[TB] FAIL mc_cur_mode: got=%0b exp=1", cur_mode); end
        total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== SEL1) begin bad++; $display("[TB] FAIL mc_selects: got=%h exp=%h", {pll_idsel, pll_fbdsel, pll_odsel}, SEL1); end
        total++; if (req_if.mode_ready !== 1'b0) begin bad++; $display("[TB] FAIL mc_mode_ready_off: got=%0b exp=0", req_if.mode_ready); end
        tick(12);
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL mc_ready_early: got=%0b exp=0", ready); end
        tick(1);
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL mc_ready_again: got=%0b exp=1", ready); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("[TB] FAIL mc_lock_lost: got=%0b exp=0", lock_lost); end
    endtask

    task automatic test_lock_loss();
        pll_lock = 1'b0;
        tick(2);
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL ll_ready_sync_delay: got=%0b exp=1", ready); end
        total++; if (req_if.mode_ready !== 1'b0) begin bad++; $display("[TB] FAIL ll_mode_ready: got=%0b exp=0", req_if.mode_ready); end
        tick(1);
        total++; if (lock_lost !== 1'b1) begin bad++; $display("[TB] FAIL ll_lock_lost: got=%0b exp=1", lock_lost); end
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL ll_ready: got=%0b exp=0", ready); end
        total++; if (video_reset !== 1'b1) begin bad++; $display("[TB] FAIL ll_video_reset: got=%0b exp=1", video_reset); end
        total++; if (pll_reset !== 1'b1) begin bad++; $display("[TB] FAIL ll_pll_reset: got=%0b exp=1", pll_reset); end
        total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== SEL1) begin bad++; $display("[TB] FAIL ll_selects: got=%h exp=%h", {pll_idsel, pll_fbdsel, pll_odsel}, SEL1); end
        pll_lock = 1'b1;
        tick(12);
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL ll_ready_early: got=%0b exp=0", ready); end
        tick(1);
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL ll_relock_ready: got=%0b exp=1", ready); end
        total++; if (lock_lost !== 1'b1) begin bad++; $display("[TB] FAIL ll_sticky: got=%0b exp=1", lock_lost); end
    endtask

    task automatic test_glitch();
        req_if.mode_sel = 1'b1; req_if.mode_valid = 1'b1;
        tick(1);
        req_if.mode_valid = 1'b0;
        total++; if (lock_lost !== 1'b0) begin bad++; $display("[TB] FAIL gl_lock_lost_clear: got=%0b exp=0", lock_lost); end
        total++; if (pll_reset !== 1'b1) begin bad++; $display("[TB] FAIL gl_same_mode_apply: got=%0b exp=1", pll_reset); end
        total++; if (cur_mode !== 1'b1) begin bad++; $display("[TB] FAIL gl_cur_mode: got=%0b exp=1", cur_mode); end
        tick(7);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(5);
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL gl_ready_unglitched_time: got=%0b exp=0", ready); end
        tick(5);
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL gl_ready_early: got=%0b exp=0", ready); end
        tick(1);
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL gl_ready: got=%0b exp=1", ready); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("[TB] FAIL gl_no_lock_lost: got=%0b exp=0", lock_lost); end
    endtask

    task automatic test_timeout();
        reset = 1'b1; pll_lock = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(35);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL to_err_early: got=%0b exp=0", timeout_err); end
        total++; if (pll_reset !== 1'b0) begin bad++; $display("[TB] FAIL to_waiting: got=%0b exp=0", pll_reset); end
        tick(1);
        total++; if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL to_err: got=%0b exp=1", timeout_err); end
        total++; if (pll_reset !== 1'b1) begin bad++; $display("[TB] FAIL to_retry_reset: got=%0b exp=1", pll_reset); end
        tick(3);
        total++; if (pll_reset !== 1'b1) begin bad++; $display("[TB] FAIL to_pulse_held: got=%0b exp=1", pll_reset); end
        tick(1);
        total++; if (pll_reset !== 1'b0) begin bad++; $display("[TB] FAIL to_pulse_end: got=%0b exp=0", pll_reset); end
        tick(31);
        total++; if (pll_reset !== 1'b0) begin bad++; $display("[TB] FAIL to_second_wait: got=%0b exp=0", pll_reset); end
        tick(1);
        total++; if (pll_reset !== 1'b1) begin bad++; $display("[TB] FAIL to_second_retry: got=%0b exp=1", pll_reset); end
        pll_lock = 1'b1;
        tick(12);
        total++; if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL to_err_sticky: got=%0b exp=1", timeout_err); end
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL to_ready_early: got=%0b exp=0", ready); end
        tick(1);
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL to_ready: got=%0b exp=1", ready); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL to_err_cleared: got=%0b exp=0", timeout_err); end
    endtask

    task automatic test_reset_midway();
        req_if.mode_sel = 1'b1; req_if.mode_valid = 1'b1;
        tick(1);
        req_if.mode_valid = 1'b0; pll_lock = 1'b0;
        tick(5);
        total++; if (cur_mode !== 1'b1) begin bad++; $display("[TB] FAIL mid_cur_mode_before: got=%0b exp=1", cur_mode); end
        total++; if (pll_reset !== 1'b0) begin bad++; $display("[TB] FAIL mid_in_wait: got=%0b exp=0", pll_reset); end
        reset = 1'b1;
        tick(1);
        total++; if (cur_mode !== 1'b0) begin bad++; $display("[TB] FAIL mid_cur_mode: got=%0b exp=0", cur_mode); end
        total++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== SEL0) begin bad++; $display("[TB] FAIL mid_selects: got=%h exp=%h", {pll_idsel, pll_fbdsel, pll_odsel}, SEL0); end
        total++; if (pll_reset !== 1'b1) begin bad++; $display("[TB] FAIL mid_pll_reset: got=%0b exp=1", pll_reset); end
        total++; if (video_reset !== 1'b1) begin bad++; $display("[TB] FAIL mid_video_reset: got=%0b exp=1", video_reset); end
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready: got=%0b exp=0", ready); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_mode_change();
        test_lock_loss();
        test_glitch();
        test_timeout();
        test_reset_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
